serial_adder_ctrl: RTL

//   Bit-serial N-bit adder with start/done handshake. Consumes one operand bit pair per

---
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_last;

    // Full adder built from two half-adder stages.
    logic w_h1_s, w_h1_c, w_s, w_h2_c, w_c_nxt;

    assign w_h1_s  = r_a_sh[0] ^ r_b_sh[0];
    assign w_h1_c  = r_a_sh[0] & r_b_sh[0];
    assign w_s     = w_h1_s ^ r_c;
    assign w_h2_c  = w_h1_s & r_c;
    assign w_c_nxt = w_h1_c | w_h2_c;
    assign w_last  = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_c    <= cin;
                r_cnt  <= '0;
            end
        end else if (r_state == RUN) begin
            r_sum  <= {w_s, r_sum[WIDTH-1:1]};
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_c    <= w_c_nxt;
            if (w_last) begin
                r_cout <= w_c_nxt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // On the final bit r_c is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_c ^ w_c_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
